// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin buffer arbiter slice.
// Grant-id width derivation and a one-hot-or-zero check.
package rr_arb_pkg;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic onehot0(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/rr_buffer_arbiter_skid_fifo2.sv
// Two-entry register FIFO catching beats already in flight
// when the consumer stalls; entry 0 is always the head.
module skid_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o,
  output logic              full_o
);

  logic [DATA_W-1:0] e0_q, e0_d;
  logic [DATA_W-1:0] e1_q, e1_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (clr_i) begin
      count_d = 2'd0;
    end else if (push_i && pop_i) begin
      if (count_q == 2'd2) begin
        e0_d = e1_q;
        e1_d = data_i;
      end else begin
        e0_d = data_i;
      end
    end else if (pop_i) begin
      e0_d    = e1_q;
      count_d = count_q - 2'd1;
    end else if (push_i) begin
      if (count_q == 2'd0) e0_d = data_i;
      else                 e1_d = data_i;
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = e0_q;
  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(push_i && count_q == 2'd2));

endmodule

// File: rtl/rr_buffer_arbiter.sv
// Round-robin grant to per-source buffers with bounded bursts;
// forwards the granted beat to one valid/ready consumer.
module rr_buffer_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [IDW-1:0]            grant_id,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      skid_full
);

  localparam int BW = id_w(MAX_BURST);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
  localparam logic [BW-1:0]  BMAX     = BW'(MAX_BURST - 1);

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic               tag_v_q;
  logic [IDW-1:0]     tag_id_q;
  logic [DATA_W-1:0]  od_q;

  logic              elig, found;
  logic [IDW-1:0]    win, cand;
  logic              live_v;
  logic [DATA_W-1:0] live_d;
  logic              push, pop, ov;
  logic [DATA_W-1:0] sel, head;
  logic [1:0]        cnt;

  assign elig = !flush && out_ready
             && (cnt == 2'd0) && (|req);

  always_comb begin
    grant_d = '0;
    gid_d   = '0;
    last_d  = last_q;
    burst_d = burst_q;
    win     = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(last_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (flush) begin
      last_d  = LAST_RST;
      burst_d = '0;
    end else if (elig) begin
      if (|grant_q && req[gid_q] && burst_q < BMAX) begin
        grant_d[gid_q] = 1'b1;
        gid_d          = gid_q;
        burst_d        = burst_q + BW'(1);
      end else begin
        grant_d[win] = 1'b1;
        gid_d        = win;
        last_d       = win;
        burst_d      = '0;
      end
    end
  end

  // Only the buffer we granted last cycle may present a beat.
  always_comb begin
    live_v = 1'b0;
    live_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (tag_id_q == IDW'(k)) begin
        live_v = tag_v_q & in_valid[k];
        live_d = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    ov   = 1'b0;
    sel  = od_q;
    if (flush) begin
      ov = 1'b0;
    end else if (cnt == 2'd0) begin
      ov   = live_v;
      sel  = live_d;
      push = live_v & !out_ready;
    end else begin
      ov   = 1'b1;
      sel  = head;
      pop  = out_ready;
      push = live_v;
    end
  end

  skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (live_d),
    .head_o  (head),
    .count_o (cnt),
    .full_o  (skid_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q  <= '0;
      gid_q    <= '0;
      last_q   <= LAST_RST;
      burst_q  <= '0;
      tag_v_q  <= 1'b0;
      tag_id_q <= '0;
      od_q     <= '0;
    end else begin
      grant_q  <= grant_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      tag_v_q  <= !flush && (|grant_q);
      tag_id_q <= gid_q;
      od_q     <= out_data;
    end
  end

  assign grant     = grant_q;
  assign grant_id  = gid_q;
  assign out_valid = ov;
  assign out_data  = ov ? sel : od_q;

  a_grant_onehot0: assert property (
    @(posedge clk) disable iff (reset)
    onehot0(32'(grant_q)));

endmodule

// File: tb/tb_rr_buffer_arbiter.sv
// Directed per-cycle vector bench for rr_buffer_arbiter
// with a simple buffer model answering grants one cycle later.
module tb_rr_buffer_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          out_ready = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  grant;
  logic [1:0]    grant_id;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          skid_full;

  always #5 clk = ~clk;

  rr_buffer_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req       (req),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .grant     (grant),
    .grant_id  (grant_id),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .skid_full (skid_full)
  );

  logic [DW-1:0] base [N];
  logic [DW-1:0] bd   [N];
  int unsigned   bcnt [N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      in_valid <= '0;
      for (int k = 0; k < N; k++) begin
        bd[k]   <= '0;
        bcnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        in_valid[k] <= grant[k];
        if (grant[k]) begin
          bd[k]   <= base[k] + DW'(bcnt[k]);
          bcnt[k] <= bcnt[k] + 1;
        end
      end
    end
  end

  always_comb begin
    in_data = '0;
    for (int k = 0; k < N; k++)
      in_data[k*DW +: DW] = bd[k];
  end

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic        fl;
    logic [3:0]  g;
    logic [1:0]  gid;
    logic        ov;
    logic        odc;
    logic [31:0] od;
    logic        full;
  } vec_t;

  vec_t vq[$];
  vec_t bp[11];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
    input logic [3:0] r, input logic rd, input logic f,
    input logic [3:0] g, input logic ov,
    input logic odc, input logic [31:0] od,
    input logic fu);
    vec_t v;
    v.req  = r;
    v.rdy  = rd;
    v.fl   = f;
    v.g    = g;
    v.gid  = g[3] ? 2'd3 : g[2] ? 2'd2 :
             g[1] ? 2'd1 : 2'd0;
    v.ov   = ov;
    v.odc  = odc;
    v.od   = od;
    v.full = fu;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_vq(input string tn);
    for (int i = 0; i < vq.size(); i++) begin
      req       = vq[i].req;
      out_ready = vq[i].rdy;
      flush     = vq[i].fl;
      @(negedge clk);
      chk($sformatf("%s c%0d grant", tn, i),
          32'(grant), 32'(vq[i].g));
      chk($sformatf("%s c%0d grant_id", tn, i),
          32'(grant_id), 32'(vq[i].gid));
      chk($sformatf("%s c%0d out_valid", tn, i),
          32'(out_valid), 32'(vq[i].ov));
      chk($sformatf("%s c%0d skid_full", tn, i),
          32'(skid_full), 32'(vq[i].full));
      if (vq[i].odc)
        chk($sformatf("%s c%0d out_data", tn, i),
            out_data, vq[i].od);
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++)
      base[k] = 32'h10 * (k + 1);

    bp[0]  = mk(4'b0001, 1, 0, 4'b0000, 0, 1, 32'h0,  0);
    bp[1]  = mk(4'b0001, 1, 0, 4'b0001, 0, 0, 32'h0,  0);
    bp[2]  = mk(4'b0001, 1, 0, 4'b0001, 1, 1, 32'h10, 0);
    bp[3]  = mk(4'b0001, 0, 0, 4'b0001, 1, 1, 32'h11, 0);
    bp[4]  = mk(4'b0001, 0, 0, 4'b0000, 1, 1, 32'h11, 0);
    bp[5]  = mk(4'b0001, 0, 0, 4'b0000, 1, 1, 32'h11, 1);
    bp[6]  = mk(4'b0001, 1, 0, 4'b0000, 1, 1, 32'h11, 1);
    bp[7]  = mk(4'b0001, 1, 0, 4'b0000, 1, 1, 32'h12, 0);
    bp[8]  = mk(4'b0001, 1, 0, 4'b0000, 0, 1, 32'h12, 0);
    bp[9]  = mk(4'b0001, 1, 0, 4'b0001, 0, 0, 32'h0,  0);
    bp[10] = mk(4'b0001, 1, 0, 4'b0001, 1, 1, 32'h13, 0);

    // single requester streams every cycle
    base[1] = 32'hA0;
    do_reset();
    vq.push_back(mk(4'b0010,1,0,4'b0000,0,1,32'h0, 0));
    vq.push_back(mk(4'b0010,1,0,4'b0010,0,0,32'h0, 0));
    vq.push_back(mk(4'b0010,1,0,4'b0010,1,1,32'hA0,0));
    vq.push_back(mk(4'b0010,1,0,4'b0010,1,1,32'hA1,0));
    vq.push_back(mk(4'b0010,1,0,4'b0010,1,1,32'hA2,0));
    vq.push_back(mk(4'b0010,1,0,4'b0010,1,1,32'hA3,0));
    vq.push_back(mk(4'b0000,1,0,4'b0010,1,1,32'hA4,0));
    vq.push_back(mk(4'b0000,1,0,4'b0000,1,1,32'hA5,0));
    vq.push_back(mk(4'b0000,1,0,4'b0000,0,1,32'hA5,0));
    run_vq("single");
    base[1] = 32'h20;

    // all requesting: bursts of four, rotating
    do_reset();
    for (int c = 0; c < 19; c++) begin
      logic [3:0] g;
      int k, idx;
      g = (c == 0) ? 4'b0000 :
          4'(1 << (((c - 1) / 4) % 4));
      if (c < 2) begin
        vq.push_back(mk(4'hF,1,0,g,0,0,32'h0,0));
      end else begin
        k   = ((c - 2) / 4) % 4;
        idx = (c - 2) % 4 + 4 * ((c - 2) / 16);
        vq.push_back(mk(4'hF,1,0,g,1,1,
                        base[k] + 32'(idx),0));
      end
    end
    run_vq("fair");

    // consumer stall fills the skid, then drains in order
    do_reset();
    for (int i = 0; i < 11; i++) vq.push_back(bp[i]);
    run_vq("bp");

    // flush drops the in-flight beat and resets the pointer
    base[1] = 32'h50;
    do_reset();
    vq.push_back(mk(4'b0010,1,0,4'b0000,0,0,32'h0, 0));
    vq.push_back(mk(4'b0010,1,0,4'b0010,0,0,32'h0, 0));
    vq.push_back(mk(4'b1010,1,1,4'b0010,0,1,32'h0, 0));
    vq.push_back(mk(4'b1010,1,0,4'b0000,0,1,32'h0, 0));
    vq.push_back(mk(4'b1010,1,0,4'b0010,0,0,32'h0, 0));
    vq.push_back(mk(4'b1010,1,0,4'b0010,1,1,32'h52,0));
    run_vq("flush");
    base[1] = 32'h20;

    // pointer at 3 wraps to requester 0
    do_reset();
    vq.push_back(mk(4'b1000,1,0,4'b0000,0,0,32'h0, 0));
    vq.push_back(mk(4'b0101,1,0,4'b1000,0,0,32'h0, 0));
    vq.push_back(mk(4'b0101,1,0,4'b0001,1,1,32'h40,0));
    vq.push_back(mk(4'b0101,1,0,4'b0001,1,1,32'h10,0));
    vq.push_back(mk(4'b0101,1,0,4'b0001,1,1,32'h11,0));
    vq.push_back(mk(4'b0101,1,0,4'b0001,1,1,32'h12,0));
    vq.push_back(mk(4'b0101,1,0,4'b0100,1,1,32'h13,0));
    vq.push_back(mk(4'b0101,1,0,4'b0100,1,1,32'h30,0));
    run_vq("wrap");

    // async reset while the skid holds two beats
    do_reset();
    for (int i = 0; i < 6; i++) vq.push_back(bp[i]);
    run_vq("arst");
    chk("arst pre skid_full", 32'(skid_full), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst grant", 32'(grant), 32'd0);
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst skid_full", 32'(skid_full), 32'd0);
    chk("arst out_data", out_data, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    vq.push_back(mk(4'b1111,1,0,4'b0000,0,0,32'h0, 0));
    vq.push_back(mk(4'b1111,1,0,4'b0001,0,0,32'h0, 0));
    vq.push_back(mk(4'b1111,1,0,4'b0001,1,1,32'h10,0));
    run_vq("post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_buffer_arbiter.md
Name: rr_buffer_arbiter

Overview:
- Downstream neighbour of the per-source buffer_slots stage.
- Takes arbiter_req from NUM_REQ buffers and issues a one-hot round-robin grant with bounded bursts.
- Collects the granted buffer's beat, which appears one cycle after grant, and forwards it to a single valid/ready consumer.
- A 2-entry skid absorbs beats already in flight when the consumer back-pressures; flush clears everything in flight.

Parameters:
- NUM_REQ, 4, number of upstream buffers (2..8).
- DATA_W, 32, beat width.
- MAX_BURST, 4, max consecutive grant cycles to one requester while others wait (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush, same cycle as buffers' flush.
- req  in  NUM_REQ  arbiter_req from each buffer.
- in_valid  in  NUM_REQ  out_valid from each buffer.
- in_data  in  NUM_REQ*DATA_W  outputs from each buffer; requester k at bits [k*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot or zero; drives each buffer's arbiter_grant.
- grant_id  out  $clog2(NUM_REQ)  index of the current grant; 0 when grant==0.
- out_valid  out  1  beat valid to consumer.
- out_data  out  DATA_W  beat data.
- out_ready  in  1  consumer accepts the beat when out_valid & out_ready.
- skid_full  out  1  skid holds 2 beats; goes to stall management.

Behaviour:
- Reset (async, active-high):
  - grant=0, grant_id=0, out_valid=0, out_data=0, skid_full=0.
  - Skid empty; rr pointer last=NUM_REQ-1; burst_cnt=0; inflight tag clear.
- grant is a registered output; a decision made in cycle t is visible in t+1.
- Grant eligibility, evaluated each cycle: eligible = !flush & out_ready & (skid_count==0) & (req!=0). Not eligible -> next grant=0.
- Arbitration when eligible:
  - Hold: if current owner o still has req[o]=1 and burst_cnt < MAX_BURST-1, keep o and increment burst_cnt.
  - Rotate: otherwise search from (last+1) mod NUM_REQ upward with wrap; the first req bit found wins. Set last=winner, burst_cnt=0.
  - A lone requester is re-granted indefinitely, since rotation finds itself.
- Inflight tag: registered copy of (grant!=0, grant_id). A beat is captured in cycle t+1 only when the tag is set and in_valid[tag_id]=1. in_valid from non-tagged requesters is ignored.
- Output mux and skid:
  - skid_count==0: out_valid = live beat valid, out_data = live data (combinational pass-through). If not accepted (out_ready=0), push the live beat into the skid.
  - skid_count>0: out_valid=1, out_data = skid head. On out_valid & out_ready, pop the head. A live beat arriving the same cycle is pushed at the tail.
  - Simultaneous push and pop keeps the count. Push with count==2 is impossible by construction; assertion required.
  - When out_valid=0, out_data shows the last presented value.
- skid_full = (skid_count==2), registered from the count.
- Flush (synchronous, priority over everything except reset):
  - Next grant=0 and inflight tag cleared, so the beat from a pre-flush grant is dropped.
  - Skid emptied; out_valid forced 0 in the flush cycle.
  - last=NUM_REQ-1, burst_cnt=0.
- Latency: grant decision t -> buffer output t+1 -> out_valid t+1 (skid empty). Throughput is 1 beat/cycle with out_ready held high.
- Mid-burst out_ready drop:
  - At most 2 beats land in the skid.
  - Grant resumes only after the skid fully drains and out_ready=1; the rr pointer is unchanged by the stall.
- Grant deassertion is always legal for buffers; they keep accepting input while ungranted.

Decomposition:
- Package rr_arb_pkg: a function deriving the grant_id width from NUM_REQ, and a ONEHOT0 check helper for assertions.
- Sub-module: skid_fifo2 (DATA_W param; push/pop/count/head/full), 2-entry register FIFO.
- Round-robin search stays inline.

Test Plan:
- Single requester: req=4'b0010, in_valid[1]=1 with data 0xA0,0xA1,0xA2, out_ready=1 -> grant=0010 every cycle; out_data 0xA0,0xA1,0xA2 on consecutive cycles, one cycle after each grant.
- Fairness/burst: req=4'b1111 constant, MAX_BURST=4 -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001...; grant_id 0,1,2,3.
- Back-pressure: stream from req0 while out_ready drops for 3 cycles after two grants -> skid_full=1; grant=0 until skid drains; no beat lost or duplicated; order 0x10,0x11,0x12...
- Flush mid-burst: grant=0001 in cycle t, flush at t+1 -> beat from t dropped; out_valid=0 at t+1; skid empty; next grant goes to lowest-index requester with req=1.
- Wrap: last=3, req=4'b0101 -> next grant 0001 (wrap to index 0), then 0100 after the burst ends.
- Async reset asserted mid-stream with skid_count=2 -> immediately grant=0, out_valid=0, skid_full=0; first post-reset grant goes to requester 0.
